// File: rtl/bp_fe_fetch_queue.sv
// Fetch queue: buffers whole fetch packets and hands them out one instruction per cycle.
// Exception packets carry a single zero instruction; empty non-exception packets are dropped.
module bp_fe_fetch_queue #(
    parameter int els_p         = 4,
    parameter int fetch_width_p = 2,
    parameter int vaddr_width_p = 39,
    parameter int meta_width_p  = 64,
    localparam int instr_width_lp = 32,
    localparam int cnt_width_lp   = $clog2(fetch_width_p + 1),
    localparam int occ_width_lp   = $clog2(els_p + 1)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    flush_i,

    input  logic                                    enq_v_i,
    output logic                                    enq_ready_and_o,
    input  logic [vaddr_width_p-1:0]                enq_pc_i,
    input  logic [fetch_width_p*instr_width_lp-1:0] enq_instr_i,
    input  logic [cnt_width_lp-1:0]                 enq_count_i,
    input  logic [1:0]                              enq_exc_i,
    input  logic [meta_width_p-1:0]                 enq_meta_i,

    output logic                                    deq_v_o,
    input  logic                                    deq_yumi_i,
    output logic [vaddr_width_p-1:0]                deq_pc_o,
    output logic [instr_width_lp-1:0]               deq_instr_o,
    output logic [1:0]                              deq_exc_o,
    output logic [meta_width_p-1:0]                 deq_meta_o,
    output logic                                    deq_last_o,
    output logic [occ_width_lp-1:0]                 occupancy_o
);

    localparam int ptr_width_lp  = $clog2(els_p);
    localparam int slot_width_lp = (fetch_width_p > 1) ? $clog2(fetch_width_p) : 1;

    logic [vaddr_width_p-1:0]                pc_mem    [els_p];
    logic [fetch_width_p*instr_width_lp-1:0] instr_mem [els_p];
    logic [cnt_width_lp-1:0]                 cnt_mem   [els_p];
    logic [1:0]                              exc_mem   [els_p];
    logic [meta_width_p-1:0]                 meta_mem  [els_p];

    logic [ptr_width_lp-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]  rd_ptr_q, rd_ptr_d;
    logic [occ_width_lp-1:0]  count_q,  count_d;
    logic [slot_width_lp-1:0] slot_q,   slot_d;

    logic                                    enq_is_exc;
    logic                                    enq_drop;
    logic                                    wr_en;
    logic [cnt_width_lp-1:0]                 enq_cnt_sat;
    logic [cnt_width_lp-1:0]                 wr_cnt;
    logic [fetch_width_p*instr_width_lp-1:0] wr_instr;
    logic [cnt_width_lp-1:0]                 head_cnt;
    logic                                    deq_fire;
    logic                                    pop;

    // Ready looks only at stored count, never at the consumer, so a full queue stays closed
    // even when the head is leaving this cycle.
    assign enq_ready_and_o = (count_q != occ_width_lp'(els_p)) & ~flush_i & ~reset_i;

    assign enq_is_exc  = (enq_exc_i != 2'b00);
    assign enq_drop    = ~enq_is_exc & (enq_count_i == '0);
    assign enq_cnt_sat = (enq_count_i > cnt_width_lp'(fetch_width_p))
                       ? cnt_width_lp'(fetch_width_p) : enq_count_i;
    assign wr_cnt      = enq_is_exc ? cnt_width_lp'(1) : enq_cnt_sat;
    assign wr_instr    = enq_is_exc ? '0 : enq_instr_i;
    assign wr_en       = enq_v_i & enq_ready_and_o & ~enq_drop;

    assign head_cnt    = cnt_mem[rd_ptr_q];
    assign deq_v_o     = (count_q != '0);
    assign deq_last_o  = (cnt_width_lp'(slot_q) == (head_cnt - cnt_width_lp'(1)));
    assign deq_pc_o    = pc_mem[rd_ptr_q] + vaddr_width_p'({slot_q, 2'b00});
    assign deq_instr_o = instr_mem[rd_ptr_q][int'(slot_q)*instr_width_lp +: instr_width_lp];
    assign deq_exc_o   = exc_mem[rd_ptr_q];
    assign deq_meta_o  = meta_mem[rd_ptr_q];
    assign occupancy_o = count_q;

    assign deq_fire    = deq_yumi_i & deq_v_o;
    assign pop         = deq_fire & deq_last_o;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        slot_d   = slot_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            slot_d   = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + ptr_width_lp'(1);
            end
            if (deq_fire) begin
                if (deq_last_o) begin
                    slot_d   = '0;
                    rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
                end else begin
                    slot_d   = slot_q + slot_width_lp'(1);
                end
            end
            count_d = count_q + occ_width_lp'(wr_en) - occ_width_lp'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            slot_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            slot_q   <= slot_d;
        end
    end

    // NOTE: packet storage has no reset; entries are only read once count marks them valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]    <= enq_pc_i;
            instr_mem[wr_ptr_q] <= wr_instr;
            cnt_mem[wr_ptr_q]   <= wr_cnt;
            exc_mem[wr_ptr_q]   <= enq_exc_i;
            meta_mem[wr_ptr_q]  <= enq_meta_i;
        end
    end

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// Directed vector table plus hand sequences (flush race, reset mid-packet) and a randomized
// run against a packet-queue reference model, for the default parameter set.
module tb_bp_fe_fetch_queue;

    logic        clk;
    logic        reset_i;
    logic        flush_i;
    logic        enq_v_i;
    logic        enq_ready_and_o;
    logic [38:0] enq_pc_i;
    logic [63:0] enq_instr_i;
    logic [1:0]  enq_count_i;
    logic [1:0]  enq_exc_i;
    logic [63:0] enq_meta_i;
    logic        deq_v_o;
    logic        deq_yumi_i;
    logic [38:0] deq_pc_o;
    logic [31:0] deq_instr_o;
    logic [1:0]  deq_exc_o;
    logic [63:0] deq_meta_o;
    logic        deq_last_o;
    logic [2:0]  occupancy_o;

    bp_fe_fetch_queue dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .flush_i         (flush_i),
        .enq_v_i         (enq_v_i),
        .enq_ready_and_o (enq_ready_and_o),
        .enq_pc_i        (enq_pc_i),
        .enq_instr_i     (enq_instr_i),
        .enq_count_i     (enq_count_i),
        .enq_exc_i       (enq_exc_i),
        .enq_meta_i      (enq_meta_i),
        .deq_v_o         (deq_v_o),
        .deq_yumi_i      (deq_yumi_i),
        .deq_pc_o        (deq_pc_o),
        .deq_instr_o     (deq_instr_o),
        .deq_exc_o       (deq_exc_o),
        .deq_meta_o      (deq_meta_o),
        .deq_last_o      (deq_last_o),
        .occupancy_o     (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic enq, input logic [38:0] pc,
                         input logic [63:0] instr, input logic [1:0] cnt, input logic [1:0] exc,
                         input logic [63:0] meta, input logic yumi);
        flush_i     = fl;
        enq_v_i     = enq;
        enq_pc_i    = pc;
        enq_instr_i = instr;
        enq_count_i = cnt;
        enq_exc_i   = exc;
        enq_meta_i  = meta;
        deq_yumi_i  = yumi;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 2'd0, 2'd0, '0, 1'b0);
    endtask

    // One table row: inputs for this cycle and the outputs expected before the next edge.
    typedef struct {
        logic        enq;
        logic [38:0] pc;
        logic [63:0] instr;
        logic [1:0]  cnt;
        logic [1:0]  exc;
        logic [63:0] meta;
        logic        yumi;
        logic        e_v;
        logic [38:0] e_pc;
        logic [31:0] e_instr;
        logic [1:0]  e_exc;
        logic [63:0] e_meta;
        logic        e_last;
        logic [2:0]  e_occ;
        logic        e_ready;
    } vec_t;

    function automatic vec_t mkv(logic enq, logic [38:0] pc, logic [63:0] instr, logic [1:0] cnt,
                                 logic [1:0] exc, logic [63:0] meta, logic yumi,
                                 logic e_v, logic [38:0] e_pc, logic [31:0] e_instr,
                                 logic [1:0] e_exc, logic [63:0] e_meta, logic e_last,
                                 logic [2:0] e_occ, logic e_ready);
        vec_t v;
        v.enq = enq;   v.pc = pc;       v.instr = instr;     v.cnt = cnt;
        v.exc = exc;   v.meta = meta;   v.yumi = yumi;
        v.e_v = e_v;   v.e_pc = e_pc;   v.e_instr = e_instr; v.e_exc = e_exc;
        v.e_meta = e_meta; v.e_last = e_last; v.e_occ = e_occ; v.e_ready = e_ready;
        return v;
    endfunction

    task automatic check_outs(input string tag, input logic e_v, input logic [38:0] e_pc,
                              input logic [31:0] e_instr, input logic [1:0] e_exc,
                              input logic [63:0] e_meta, input logic e_last,
                              input logic [2:0] e_occ, input logic e_ready);
        check({tag, " deq_v"}, deq_v_o, e_v);
        check({tag, " occupancy"}, occupancy_o, e_occ);
        check({tag, " ready"}, enq_ready_and_o, e_ready);
        if (e_v) begin
            check({tag, " pc"}, deq_pc_o, e_pc);
            check({tag, " instr"}, deq_instr_o, e_instr);
            check({tag, " exc"}, deq_exc_o, e_exc);
            check({tag, " meta"}, deq_meta_o, e_meta);
            check({tag, " last"}, deq_last_o, e_last);
        end
    endtask

    localparam logic [38:0] PC_TOP = 39'h7F_FFFF_FFFC;

    typedef struct {
        logic [38:0] pc;
        logic [63:0] instr;
        int          cnt;
        logic [1:0]  exc;
        logic [63:0] meta;
    } pkt_t;

    vec_t vq[$];
    pkt_t mq[$];
    int   mslot;

    initial begin
        reset_i = 1'b0;
        idle();

        // Reset state
        #1 reset_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_outs("reset", 1'b0, '0, '0, '0, '0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        reset_i = 1'b0;
        #1 check_outs("reset_release", 1'b0, '0, '0, '0, '0, 1'b0, 3'd0, 1'b1);

        // Unpack, with a yumi while empty that must be ignored
        vq.push_back(mkv(1, 'h1000, 64'h0000000B_0000000A, 2, 0, 'hA1, 1,  0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, 'h1000, 'hA, 0, 'hA1, 0, 1, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, 'h1004, 'hB, 0, 'hA1, 1, 1, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        // Exception packet: one slot, zero instruction
        vq.push_back(mkv(1, 'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 'hE2, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, 'h2000, 0, 2, 'hE2, 1, 1, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        // Empty non-exception packet is dropped
        vq.push_back(mkv(1, 'h3000, 'h1234, 0, 0, 'h33, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        // PC wraps to zero on the second slot
        vq.push_back(mkv(1, PC_TOP, 64'h0000000D_0000000C, 2, 0, 'h44, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, PC_TOP, 'hC, 0, 'h44, 0, 1, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, 0, 'hD, 0, 'h44, 1, 1, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        // Count 3 saturates to 2
        vq.push_back(mkv(1, 'h4000, 64'h0000000F_0000000E, 3, 0, 'h55, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, 'h4000, 'hE, 0, 'h55, 0, 1, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, 'h4004, 'hF, 0, 'h55, 1, 1, 1));
        // Single-slot packet
        vq.push_back(mkv(1, 'h5000, 64'h0000DEAD_00000011, 1, 0, 'h66, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, 'h5000, 'h11, 0, 'h66, 1, 1, 1));
        // Fill to full; 0x500 and 0x800 are refused
        vq.push_back(mkv(1, 'h100, 'h100, 1, 0, 'h10, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mkv(1, 'h200, 'h200, 1, 0, 'h20, 0,  1, 'h100, 'h100, 0, 'h10, 1, 1, 1));
        vq.push_back(mkv(1, 'h300, 'h300, 1, 0, 'h30, 0,  1, 'h100, 'h100, 0, 'h10, 1, 2, 1));
        vq.push_back(mkv(1, 'h400, 'h400, 1, 0, 'h40, 0,  1, 'h100, 'h100, 0, 'h10, 1, 3, 1));
        vq.push_back(mkv(1, 'h500, 'h500, 1, 0, 'h50, 0,  1, 'h100, 'h100, 0, 'h10, 1, 4, 0));
        vq.push_back(mkv(1, 'h800, 'h800, 1, 0, 'h80, 1,  1, 'h100, 'h100, 0, 'h10, 1, 4, 0));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, 'h200, 'h200, 0, 'h20, 1, 3, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, 'h300, 'h300, 0, 'h30, 1, 2, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, 'h400, 'h400, 0, 'h40, 1, 1, 1));
        // Simultaneous enqueue and final-slot dequeue keeps count
        vq.push_back(mkv(1, 'h600, 'h600, 1, 0, 'h60, 0,  0, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mkv(1, 'h700, 'h700, 1, 0, 'h70, 1,  1, 'h600, 'h600, 0, 'h60, 1, 1, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 1,  1, 'h700, 'h700, 0, 'h70, 1, 1, 1));
        vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(1'b0, vq[i].enq, vq[i].pc, vq[i].instr, vq[i].cnt, vq[i].exc, vq[i].meta,
                  vq[i].yumi);
            #1 check_outs($sformatf("vec%0d", i), vq[i].e_v, vq[i].e_pc, vq[i].e_instr,
                          vq[i].e_exc, vq[i].e_meta, vq[i].e_last, vq[i].e_occ, vq[i].e_ready);
        end

        // Flush race: three packets queued, head partially consumed
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 39'hA000 + 39'(i) * 39'h1000, 64'h2_0000_0001, 2'd2, 2'd0,
                  64'h77, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 2'd0, 2'd0, '0, 1'b1);
        #1 check("flush_pre head pc", deq_pc_o, 39'hA000);
        check("flush_pre occupancy", occupancy_o, 3'd3);
        @(negedge clk);
        drive(1'b1, 1'b1, 39'hF000, 64'h3_0000_0003, 2'd2, 2'd0, 64'h99, 1'b1);
        #1 check("flush ready low", enq_ready_and_o, 1'b0);
        @(negedge clk);
        idle();
        #1 check("flush occupancy", occupancy_o, 3'd0);
        check("flush deq_v", deq_v_o, 1'b0);
        check("flush ready back", enq_ready_and_o, 1'b1);
        @(negedge clk);
        #1 check("flush no ghost", deq_v_o, 1'b0);
        drive(1'b0, 1'b1, 39'hD000, 64'h0000_0002_0000_0001, 2'd2, 2'd0, 64'h88, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 2'd0, 2'd0, '0, 1'b1);
        #1 check("post_flush pc", deq_pc_o, 39'hD000);
        check("post_flush instr", deq_instr_o, 32'h1);
        check("post_flush last", deq_last_o, 1'b0);
        @(negedge clk);
        #1 check("post_flush pc2", deq_pc_o, 39'hD004);
        check("post_flush last2", deq_last_o, 1'b1);
        @(negedge clk);
        idle();
        #1 check("post_flush empty", deq_v_o, 1'b0);

        // Reset mid-packet
        drive(1'b0, 1'b1, 39'hE000, 64'h0000_0006_0000_0005, 2'd2, 2'd0, 64'h11, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 2'd0, 2'd0, '0, 1'b1);
        @(negedge clk);
        idle();
        #1 check("mid_pkt slot", deq_pc_o, 39'hE004);
        #2 reset_i = 1'b1;
        #1 check("rst_mid deq_v", deq_v_o, 1'b0);
        check("rst_mid occupancy", occupancy_o, 3'd0);
        check("rst_mid ready", enq_ready_and_o, 1'b0);
        @(negedge clk);
        reset_i = 1'b0;
        #1 check("rst_mid release ready", enq_ready_and_o, 1'b1);
        check("rst_mid release deq_v", deq_v_o, 1'b0);
        drive(1'b0, 1'b1, 39'h9000, 64'h0000_0008_0000_0007, 2'd2, 2'd0, 64'h22, 1'b0);
        @(negedge clk);
        idle();
        #1 check("rst_mid new pc", deq_pc_o, 39'h9000);
        check("rst_mid new instr", deq_instr_o, 32'h7);

        // Randomized run against a packet-queue model
        @(negedge clk);
        drive(1'b1, 1'b0, '0, '0, 2'd0, 2'd0, '0, 1'b0);
        @(posedge clk);
        mq.delete();
        mslot = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        fl, enq, yumi, e_ready, pop_last;
            logic [1:0]  cnt, exc;
            logic [38:0] pc;
            logic [63:0] instr, meta;
            pkt_t        p;
            @(negedge clk);
            fl    = ($urandom_range(0, 39) == 0);
            enq   = $urandom_range(0, 1) == 1;
            yumi  = $urandom_range(0, 2) != 0;
            cnt   = 2'($urandom_range(0, 3));
            exc   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            pc    = {$urandom, $urandom} & 39'h7F_FFFF_FFFC;
            instr = {$urandom, $urandom};
            meta  = {$urandom, $urandom};
            drive(fl, enq, pc, instr, cnt, exc, meta, yumi);
            #1;
            e_ready  = (mq.size() != 4) && !fl;
            pop_last = 1'b0;
            if (mq.size() != 0) begin
                pop_last = (mslot == mq[0].cnt - 1);
                check_outs($sformatf("rnd%0d", c), 1'b1,
                           mq[0].pc + 39'(4 * mslot), mq[0].instr[mslot*32 +: 32],
                           mq[0].exc, mq[0].meta, pop_last, 3'(mq.size()), e_ready);
            end else begin
                check_outs($sformatf("rnd%0d", c), 1'b0, '0, '0, '0, '0, 1'b0, 3'd0, e_ready);
            end
            @(posedge clk);
            if (fl) begin
                mq.delete();
                mslot = 0;
            end else begin
                if (yumi && mq.size() != 0) begin
                    if (pop_last) begin
                        void'(mq.pop_front());
                        mslot = 0;
                    end else begin
                        mslot++;
                    end
                end
                if (enq && e_ready && !(exc == 2'd0 && cnt == 2'd0)) begin
                    p.pc    = pc;
                    p.exc   = exc;
                    p.meta  = meta;
                    p.cnt   = (exc != 2'd0) ? 1 : ((cnt > 2) ? 2 : int'(cnt));
                    p.instr = (exc != 2'd0) ? 64'd0 : instr;
                    mq.push_back(p);
                end
            end
        end

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
